// File: rtl/knockout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : knockout_pkg
//  Description : Shared types and helpers for the knockout bracket engine:
//                FSM state encoding, result_sel encodings, width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package knockout_pkg;

    // Tournament engine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // result_sel encodings
    localparam logic HOME_WINS = 1'b0;
    localparam logic AWAY_WINS = 1'b1;

    // Bits needed to index n items, never less than one bit
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : knockout_pkg
`default_nettype wire

// File: rtl/knockout_history.sv
`default_nettype none
// ============================================================================
//  Module      : knockout_history
//  Description : Register file recording the winner of every transfer in
//                play order. Write pointer restarts on clear (start) and rst;
//                combinational read, out-of-range addresses read as zero.
//                Only instantiated when KNOCKOUT_HISTORY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module knockout_history #(
    parameter int NUM_TEAMS = 8,
    parameter int ID_W      = 3,
    parameter int RND_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_data,
    input  logic [RND_W:0]   rd_addr,
    output logic [ID_W-1:0]  rd_data
);

    localparam int DEPTH = NUM_TEAMS - 1;

    logic [ID_W-1:0] r_mem [DEPTH];
    logic [RND_W:0]  r_ptr;

    // Append each winner at the write pointer; pointer restarts on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_ptr <= '0;
        end else if (clear) begin
            r_ptr <= '0;
        end else if (wr_en && (int'(r_ptr) < DEPTH)) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (int'(r_ptr) == k) begin
                    r_mem[k] <= wr_data;
                end
            end
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Read mux; addresses past the last entry return zero
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(rd_addr) == k) begin
                rd_data = r_mem[k];
            end
        end
    end

endmodule : knockout_history
`default_nettype wire

// File: rtl/knockout_bracket.sv
`default_nettype none
// ============================================================================
//  Module      : knockout_bracket
//  Description : Sequential single-elimination tournament engine. Loads a
//                bracket of NUM_TEAMS team IDs, presents one match per
//                handshake, compacts winners in place round by round and
//                reports the champion.
//                Optional match-winner history enabled by the macro
//                KNOCKOUT_HISTORY_EN (otherwise hist_rd_data reads zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module knockout_bracket
    import knockout_pkg::*;
#(
    parameter int NUM_TEAMS = 8,
    parameter int ID_W      = width_of(NUM_TEAMS),
    parameter int RND_W     = width_of(NUM_TEAMS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_TEAMS*ID_W-1:0] team_ids,
    output logic                      match_valid,
    output logic [ID_W-1:0]           match_home,
    output logic [ID_W-1:0]           match_away,
    output logic [RND_W-1:0]          match_round,
    output logic [RND_W-1:0]          match_idx,
    input  logic                      result_valid,
    input  logic                      result_sel,
    output logic                      busy,
    output logic [ID_W-1:0]           champion,
    output logic                      champion_valid,
    input  logic [RND_W:0]            hist_rd_addr,
    output logic [ID_W-1:0]           hist_rd_data
);

    // Remaining-team counter must hold NUM_TEAMS itself
    localparam int              CNT_W  = $clog2(NUM_TEAMS) + 1;
    localparam logic [CNT_W-1:0] c_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(NUM_TEAMS);

    state_t            r_state;
    state_t            w_state_next;
    logic [ID_W-1:0]   r_slots [NUM_TEAMS];
    logic [RND_W-1:0]  r_round;
    logic [RND_W-1:0]  r_match;
    logic [CNT_W-1:0]  r_remaining;
    logic [ID_W-1:0]   r_champion;
    logic              r_champion_valid;

    logic              w_start;
    logic              w_transfer;
    logic              w_last_in_round;
    logic              w_final;
    logic [ID_W-1:0]   w_home;
    logic [ID_W-1:0]   w_away;
    logic [ID_W-1:0]   w_winner;

    assign w_start         = start && (r_state != PLAY);
    assign w_transfer      = (r_state == PLAY) && result_valid;
    assign w_last_in_round = (int'(r_match) == ((int'(r_remaining) >> 1) - 1));
    assign w_final         = (r_remaining == c_TWO);
    assign w_winner        = (result_sel == AWAY_WINS) ? w_away : w_home;

    // Select the pair of slots for the current match
    always_comb begin
        w_home = '0;
        w_away = '0;
        for (int k = 0; k < NUM_TEAMS / 2; k++) begin
            if (int'(r_match) == k) begin
                w_home = r_slots[2*k];
                w_away = r_slots[2*k+1];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and match presentation outputs
    always_comb begin
        w_state_next = r_state;
        match_valid  = 1'b0;
        busy         = 1'b0;
        match_home   = '0;
        match_away   = '0;
        match_round  = '0;
        match_idx    = '0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = PLAY;
                end
            end
            PLAY: begin
                match_valid = 1'b1;
                busy        = 1'b1;
                match_home  = w_home;
                match_away  = w_away;
                match_round = r_round;
                match_idx   = r_match;
                if (w_transfer && w_last_in_round && w_final) begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bracket load, in-place winner compaction, round and champion tracking.
    // Writing slot[match] never clobbers an unplayed pair because match <= 2*match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TEAMS; k++) begin
                r_slots[k] <= '0;
            end
            r_round          <= '0;
            r_match          <= '0;
            r_remaining      <= '0;
            r_champion       <= '0;
            r_champion_valid <= 1'b0;
        end else if (w_start) begin
            for (int k = 0; k < NUM_TEAMS; k++) begin
                r_slots[k] <= team_ids[k*ID_W +: ID_W];
            end
            r_round          <= '0;
            r_match          <= '0;
            r_remaining      <= c_FULL;
            r_champion       <= '0;
            r_champion_valid <= 1'b0;
        end else if (w_transfer) begin
            for (int k = 0; k < NUM_TEAMS / 2; k++) begin
                if (int'(r_match) == k) begin
                    r_slots[k] <= w_winner;
                end
            end
            if (w_last_in_round) begin
                r_remaining <= r_remaining >> 1;
                r_match     <= '0;
                r_round     <= r_round + 1'b1;
                if (w_final) begin
                    r_champion       <= w_winner;
                    r_champion_valid <= 1'b1;
                end
            end else begin
                r_match <= r_match + 1'b1;
            end
        end
    end

    assign champion       = r_champion;
    assign champion_valid = r_champion_valid;

`ifdef KNOCKOUT_HISTORY_EN
    knockout_history #(
        .NUM_TEAMS (NUM_TEAMS),
        .ID_W      (ID_W),
        .RND_W     (RND_W)
    ) u_history (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start),
        .wr_en   (w_transfer),
        .wr_data (w_winner),
        .rd_addr (hist_rd_addr),
        .rd_data (hist_rd_data)
    );
`else
    // No history storage: read port stays at zero
    logic w_unused_hist;
    assign w_unused_hist = ^hist_rd_addr;
    assign hist_rd_data  = '0;
`endif

endmodule : knockout_bracket
`default_nettype wire

// File: tb/tb_knockout_bracket.sv
`default_nettype none
// ============================================================================
//  Module      : tb_knockout_bracket
//  Description : Self-checking bench for knockout_bracket. Table-driven
//                4-team vectors, a hand-written 2-team sequence, and 8-team
//                randomized tournaments checked against a queue-based
//                round-by-round reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_knockout_bracket;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- 8-team instance ----------------
    logic        start8, rv8, sel8, mv8, busy8, cv8;
    logic [23:0] ids8;
    logic [2:0]  home8, away8, round8, idx8, champ8, hdata8;
    logic [3:0]  haddr8;
    logic [17:0] w_out8;
    assign w_out8 = {mv8, busy8, home8, away8, round8, idx8, cv8, champ8};

    knockout_bracket #(.NUM_TEAMS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .team_ids(ids8),
        .match_valid(mv8), .match_home(home8), .match_away(away8),
        .match_round(round8), .match_idx(idx8),
        .result_valid(rv8), .result_sel(sel8), .busy(busy8),
        .champion(champ8), .champion_valid(cv8),
        .hist_rd_addr(haddr8), .hist_rd_data(hdata8)
    );

    // ---------------- 4-team instance ----------------
    logic        start4, rv4, sel4, mv4, busy4, cv4;
    logic [7:0]  ids4;
    logic [1:0]  home4, away4, round4, idx4, champ4, hdata4;
    logic [2:0]  haddr4;
    logic [12:0] w_out4;
    assign w_out4 = {mv4, busy4, home4, away4, round4, idx4, cv4, champ4};

    knockout_bracket #(.NUM_TEAMS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .team_ids(ids4),
        .match_valid(mv4), .match_home(home4), .match_away(away4),
        .match_round(round4), .match_idx(idx4),
        .result_valid(rv4), .result_sel(sel4), .busy(busy4),
        .champion(champ4), .champion_valid(cv4),
        .hist_rd_addr(haddr4), .hist_rd_data(hdata4)
    );

    // ---------------- 2-team instance ----------------
    logic        start2, rv2, sel2, mv2, busy2, cv2;
    logic [1:0]  ids2, haddr2;
    logic [0:0]  home2, away2, round2, idx2, champ2, hdata2;
    logic [7:0]  w_out2;
    assign w_out2 = {mv2, busy2, home2, away2, round2, idx2, cv2, champ2};

    knockout_bracket #(.NUM_TEAMS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .team_ids(ids2),
        .match_valid(mv2), .match_home(home2), .match_away(away2),
        .match_round(round2), .match_idx(idx2),
        .result_valid(rv2), .result_sel(sel2), .busy(busy2),
        .champion(champ2), .champion_valid(cv2),
        .hist_rd_addr(haddr2), .hist_rd_data(hdata2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (8 teams) ----------------
    // Teams still alive this round sit in m_cur; winners queue up in m_nxt.
    int m_cur[$];
    int m_nxt[$];
    bit m_play;
    int m_midx, m_round, m_champ;
    bit m_cv;
    int m_hist[7];
    int m_hcnt;

    function automatic void m_reset();
        m_cur.delete();
        m_nxt.delete();
        m_play  = 0;
        m_midx  = 0;
        m_round = 0;
        m_champ = 0;
        m_cv    = 0;
        m_hcnt  = 0;
        for (int i = 0; i < 7; i++) m_hist[i] = 0;
    endfunction

    function automatic void m_step(input bit st, input bit rv, input bit sel);
        int h, a, w;
        if (!m_play) begin
            if (st) begin
                m_cur.delete();
                m_nxt.delete();
                for (int k = 0; k < 8; k++) m_cur.push_back(int'(ids8[k*3 +: 3]));
                m_midx  = 0;
                m_round = 0;
                m_play  = 1;
                m_cv    = 0;
                m_champ = 0;
                m_hcnt  = 0;
            end
        end else if (rv) begin
            h = m_cur[2*m_midx];
            a = m_cur[2*m_midx+1];
            w = sel ? a : h;
            m_nxt.push_back(w);
            m_hist[m_hcnt] = w;
            m_hcnt++;
            if (2 * (m_midx + 1) == m_cur.size()) begin
                if (m_cur.size() == 2) begin
                    m_play  = 0;
                    m_champ = w;
                    m_cv    = 1;
                end else begin
                    m_cur = m_nxt;
                    m_nxt.delete();
                    m_midx = 0;
                    m_round++;
                end
            end else begin
                m_midx++;
            end
        end
    endfunction

    function automatic logic [17:0] m_expect();
        logic [2:0] h, a, r, i;
        h = '0; a = '0; r = '0; i = '0;
        if (m_play) begin
            h = 3'(m_cur[2*m_midx]);
            a = 3'(m_cur[2*m_midx+1]);
            r = 3'(m_round);
            i = 3'(m_midx);
        end
        return {m_play, m_play, h, a, r, i, m_cv, 3'(m_champ)};
    endfunction

    function automatic logic [2:0] m_hist_exp(input int addr);
`ifdef KNOCKOUT_HISTORY_EN
        return (addr < 7) ? 3'(m_hist[addr]) : 3'd0;
`else
        return (addr < 0) ? 3'd1 : 3'd0;
`endif
    endfunction

    // One 8-team cycle: check outputs against the model, then drive inputs
    task automatic cycle8(input bit st, input bit rv, input bit sel, input string tag);
        int addr;
        addr   = $urandom_range(0, 8);
        haddr8 = 4'(addr);
        #1;
        check({tag, "_outs"}, 64'(w_out8), 64'(m_expect()));
        check({tag, "_hist"}, 64'(hdata8), 64'(m_hist_exp(addr)));
        start8 = st;
        rv8    = rv;
        sel8   = sel;
        m_step(st, rv, sel);
        @(negedge clk);
    endtask

    // ---------------- 4-team vector table ----------------
    typedef struct {
        bit         st;
        bit         rv;
        bit         sel;
        bit         mv;
        logic [1:0] home;
        logic [1:0] away;
        logic [1:0] rnd;
        logic [1:0] idx;
        bit         cv;
        logic [1:0] ch;
    } vec4_t;

    vec4_t tab[11];
    int    hexp4[4];

    initial begin
        // outputs checked before the row's inputs are driven
        tab[0]  = '{1, 0, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0};
        tab[1]  = '{0, 1, 0,  1, 2'd0, 2'd1, 2'd0, 2'd0, 0, 2'd0};
        tab[2]  = '{0, 1, 0,  1, 2'd2, 2'd3, 2'd0, 2'd1, 0, 2'd0};
        tab[3]  = '{0, 1, 0,  1, 2'd0, 2'd2, 2'd1, 2'd0, 0, 2'd0};
        tab[4]  = '{1, 1, 1,  0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd0};
        tab[5]  = '{1, 0, 0,  1, 2'd0, 2'd1, 2'd0, 2'd0, 0, 2'd0};
        tab[6]  = '{0, 1, 1,  1, 2'd0, 2'd1, 2'd0, 2'd0, 0, 2'd0};
        tab[7]  = '{0, 1, 0,  1, 2'd2, 2'd3, 2'd0, 2'd1, 0, 2'd0};
        tab[8]  = '{0, 1, 1,  1, 2'd1, 2'd2, 2'd1, 2'd0, 0, 2'd0};
        tab[9]  = '{0, 1, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd2};
        tab[10] = '{0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd2};
`ifdef KNOCKOUT_HISTORY_EN
        hexp4 = '{1, 2, 2, 0};
`else
        hexp4 = '{0, 0, 0, 0};
`endif

        rst = 1'b1;
        start8 = 0; rv8 = 0; sel8 = 0; ids8 = '0; haddr8 = '0;
        start4 = 0; rv4 = 0; sel4 = 0; ids4 = {2'd3, 2'd2, 2'd1, 2'd0}; haddr4 = '0;
        start2 = 0; rv2 = 0; sel2 = 0; ids2 = 2'b01; haddr2 = '0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset8", 64'(w_out8), 64'd0);
        check("reset4", 64'(w_out4), 64'd0);
        check("reset2", 64'(w_out2), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 4 teams: home-always tournament, then restart and 1,0,1 with a stall
        for (int r = 0; r < 11; r++) begin
            #1;
            check($sformatf("t4_row%0d", r), 64'(w_out4),
                  64'({tab[r].mv, tab[r].mv, tab[r].home, tab[r].away,
                       tab[r].rnd, tab[r].idx, tab[r].cv, tab[r].ch}));
            start4 = tab[r].st;
            rv4    = tab[r].rv;
            sel4   = tab[r].sel;
            @(negedge clk);
        end
        start4 = 0; rv4 = 0;
        for (int a = 0; a < 4; a++) begin
            haddr4 = 3'(a);
            #1;
            check($sformatf("t4_hist%0d", a), 64'(hdata4), 64'(hexp4[a]));
        end

        // 2 teams: single match, away wins
        @(negedge clk);
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        #1;
        check("t2_match", 64'(w_out2), 64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        rv2 = 1; sel2 = 1;
        @(negedge clk);
        rv2 = 0;
        #1;
        check("t2_done", 64'(w_out2), 64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);

        // 8 teams, ids 7..0, away wins on every consecutive cycle
        for (int k = 0; k < 8; k++) ids8[k*3 +: 3] = 3'(7 - k);
        cycle8(1, 0, 0, "tp3_start");
        for (int c = 0; c < 7; c++) cycle8(0, 1, 1, "tp3_play");
        cycle8(0, 1, 0, "tp3_done");
        #1;
        check("tp3_champ", 64'({cv8, champ8}), 64'({1'b1, 3'd0}));

        // Randomized tournaments with stalls, stray starts and DONE results
        for (int t = 0; t < 20; t++) begin
            ids8 = 24'($urandom);
            cycle8(1, 0, 0, "rnd_start");
            for (int c = 0; c < 60 && m_play; c++) begin
                cycle8($urandom_range(0, 7) == 0,
                       (c >= 30) || ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), "rnd_play");
            end
            cycle8(0, 1, 1'($urandom_range(0, 1)), "rnd_done");
            cycle8(0, 0, 0, "rnd_hold");
        end

        // Asynchronous reset mid-tournament after two transfers
        ids8 = 24'($urandom);
        cycle8(1, 0, 0, "ar_start");
        cycle8(0, 1, 1'($urandom_range(0, 1)), "ar_play");
        cycle8(0, 1, 1'($urandom_range(0, 1)), "ar_play");
        start8 = 0; rv8 = 0;
        #2 rst = 1'b1;
        haddr8 = 4'd0;
        #1;
        check("ar_outs", 64'(w_out8), 64'd0);
        check("ar_hist", 64'(hdata8), 64'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        ids8 = 24'($urandom);
        cycle8(0, 0, 0, "ar_idle");
        cycle8(1, 0, 0, "ar_restart");
        for (int c = 0; c < 7; c++) cycle8(0, 1, 1'($urandom_range(0, 1)), "ar_replay");
        cycle8(0, 0, 0, "ar_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_knockout_bracket
`default_nettype wire

// File: doc/knockout_bracket.md
Name: knockout_bracket

Overview:
Sequential, parametrised single-elimination tournament engine for NUM_TEAMS entrants (power of two).
- Loads a bracket of team IDs and presents one match per handshake.
- Accepts a one-bit winner selection per match, advances winners round by round, and reports the champion.
- Successor to the fixed 4-team combinational selector; generalises team count and ID width and adds match sequencing, round tracking and a result handshake.

Parameters:
NUM_TEAMS, 8, entrant count; power of two, >= 2
ID_W, $clog2(NUM_TEAMS), team ID width; >= 1
RND_W, $clog2(NUM_TEAMS), width of round index; >= 1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  load bracket and begin; honoured only in IDLE or DONE
team_ids  in  NUM_TEAMS*ID_W  initial bracket; slot k = bits [k*ID_W +: ID_W]
match_valid  out  1  a match is presented
match_home  out  ID_W  first team of current match
match_away  out  ID_W  second team of current match
match_round  out  RND_W  current round, 0 = first round
match_idx  out  RND_W  match number within the round
result_valid  in  1  result offered; accepted only when match_valid = 1
result_sel  in  1  0 = home wins, 1 = away wins
busy  out  1  high in PLAY
champion  out  ID_W  tournament winner
champion_valid  out  1  champion is valid
hist_rd_addr  in  RND_W+1  history read index (0..NUM_TEAMS-2)
hist_rd_data  out  ID_W  winner of match hist_rd_addr, in play order

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs 0; slots, round, match, remaining and history cleared.
- State IDLE / DONE, start = 1:
  - slots[k] <= team_ids slot k; round <= 0; match <= 0; remaining <= NUM_TEAMS.
  - Go to PLAY; match_valid is high the next cycle.
  - champion_valid clears on the same edge.
- State PLAY outputs:
  - match_valid = 1, busy = 1.
  - match_home = slots[2*match], match_away = slots[2*match+1].
  - match_round = round, match_idx = match.
- Handshake: a transfer occurs on a rising edge with match_valid & result_valid.
  - winner = result_sel ? away : home; slots[match] <= winner.
  - In-place compaction is safe because match <= 2*match.
- After each transfer:
  - If match == remaining/2 - 1 (last match of round): remaining <= remaining/2, match <= 0, round <= round + 1.
  - If remaining/2 == 1: go to DONE, champion <= winner, champion_valid <= 1.
  - Otherwise: match <= match + 1.
- Next match is presented the cycle after a transfer, giving one match per cycle at full throughput. Total transfers per tournament = NUM_TEAMS - 1.
- DONE:
  - match_valid = 0, busy = 0.
  - champion and champion_valid held until the next start or rst.
- Ignored events:
  - result_valid outside PLAY has no effect.
  - start during PLAY has no effect; the tournament continues.
- Simultaneous start and result_valid in IDLE/DONE: start wins and the result is ignored.
- rst during PLAY aborts immediately to IDLE; no partial champion is reported.
- NUM_TEAMS = 2: a single match, round 0; DONE follows the first transfer.

Optional Feature:
Macro KNOCKOUT_HISTORY_EN.
- Defined:
  - NUM_TEAMS-1 entry register file; entry n holds the winner of the n-th transfer since start.
  - Write pointer resets to 0 on start and rst.
  - hist_rd_data = entry[hist_rd_addr], combinational.
  - Reading an address >= NUM_TEAMS-1 returns 0.
- Undefined: no storage; hist_rd_data tied to 0; ports remain.

Decomposition:
- Package knockout_pkg holds:
  - state enum {IDLE, PLAY, DONE};
  - width helper function for ID_W/RND_W;
  - result_sel encodings HOME_WINS = 0, AWAY_WINS = 1.
- Sub-module knockout_history wraps the optional history register file (write port, pointer, read mux). It is instantiated only under KNOCKOUT_HISTORY_EN.

Test Plan:
- NUM_TEAMS = 4, ids {0,1,2,3}, start, result_sel 0,0,0 -> matches (0v1, r0 m0), (2v3, r0 m1), (0v2, r1 m0); champion = 0, champion_valid high the cycle after the 3rd transfer.
- NUM_TEAMS = 4, ids {0,1,2,3}, result_sel 1,0,1 -> final is 1v2; champion = 2. With KNOCKOUT_HISTORY_EN, history = {1,2,2}.
- NUM_TEAMS = 8, ids {7..0}, result_sel held at 1 every cycle -> 7 transfers on consecutive cycles; rounds 0,0,0,0,1,1,2; champion = 0.
- Mid-PLAY start pulse and result_valid asserted in DONE -> no state change; champion stays stable.
- rst asserted asynchronously after 2 transfers (between clock edges) -> outputs 0 immediately, state IDLE. A new start replays from round 0 with fresh ids.
- NUM_TEAMS = 2, ids {1,0}, result_sel 1 -> one match, then DONE; champion = 0.
